// File: rtl/jogo_pkg.sv
// Shared definitions for the drone game lives/respawn logic:
// FSM encoding, default timing parameters and the initial-lives table.
package jogo_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    ATIVO        = 4'd1,
    DECREMENTA   = 4'd2,
    INVULNERAVEL = 4'd3,
    FIM          = 4'd4
  } estado_t;

  localparam int VIDAS_W_PAD   = 4;
  localparam int INV_TICKS_PAD = 8;
  localparam int PISCA_DIV_PAD = 2;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  // Lives selected at game start: 2*sel+1, giving 1, 3, 5 or 7.
  function automatic logic [3:0] vidas_iniciais(input logic [1:0] sel);
    return {1'b0, sel, 1'b1};
  endfunction

endpackage

// File: rtl/contador_ticks.sv
// Mod-N event counter: advances on conta, clears on zera, and flags the
// count event that wraps it back to zero.
module contador_ticks #(
  parameter int N = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int             W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]   ULTIMO = W'(N - 1);

  logic [W-1:0] r_cont;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_cont <= '0;
    else if (zera)
      r_cont <= '0;
    else if (conta)
      r_cont <= (r_cont == ULTIMO) ? '0 : r_cont + 1'b1;
  end

  assign fim = conta && (r_cont == ULTIMO);

endmodule

// File: rtl/gerenciador_vidas.sv
// Lives/respawn controller: charges one life per accepted collision, then
// holds a tick-timed invulnerability window with a blinking drone.
module gerenciador_vidas
  import jogo_pkg::*;
#(
  parameter int VIDAS_W   = VIDAS_W_PAD,
  parameter int INV_TICKS = INV_TICKS_PAD,
  parameter int PISCA_DIV = PISCA_DIV_PAD
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic [1:0]         vidas_sel,
  input  logic               colisao,
  input  logic               tick,
  output logic [VIDAS_W-1:0] vidas,
  output logic               colisao_aceita,
  output logic               invulneravel,
  output logic               pisca,
  output logic               sem_vidas,
  output logic [3:0]         db_estado
);

  localparam logic [VIDAS_W-1:0] UMA_VIDA = VIDAS_W'(1);

  estado_t             r_estado, w_prox;
  logic [VIDAS_W-1:0]  r_vidas;
  logic                r_pisca;
  logic                w_zera, w_conta, w_fim_janela, w_fim_pisca;

  // Both counters only run inside the window; a tick during DECREMENTA is dropped.
  assign w_zera  = carrega || (r_estado != INVULNERAVEL);
  assign w_conta = tick && (r_estado == INVULNERAVEL);

  contador_ticks #(.N(INV_TICKS)) u_janela (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .fim   (w_fim_janela)
  );

  contador_ticks #(.N(PISCA_DIV)) u_pisca (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .fim   (w_fim_pisca)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    if (carrega) begin
      w_prox = ATIVO;
    end else begin
      case (r_estado)
        OCIOSO:       w_prox = OCIOSO;
        ATIVO:        if (colisao) w_prox = DECREMENTA;
        DECREMENTA:   w_prox = (r_vidas <= UMA_VIDA) ? FIM : INVULNERAVEL;
        INVULNERAVEL: if (w_fim_janela) w_prox = ATIVO;
        FIM:          w_prox = FIM;
        default:      w_prox = OCIOSO;
      endcase
    end
  end

  // Lives saturate at zero so a stray DECREMENTA can never wrap the counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_vidas <= '0;
    else if (carrega)
      r_vidas <= VIDAS_W'(vidas_iniciais(vidas_sel));
    else if (r_estado == DECREMENTA && r_vidas != '0)
      r_vidas <= r_vidas - 1'b1;
    else if (r_estado == FIM)
      r_vidas <= '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_pisca <= 1'b0;
    else if (carrega)
      r_pisca <= 1'b0;
    else if (r_estado == DECREMENTA)
      r_pisca <= 1'b1;
    else if (r_estado == INVULNERAVEL) begin
      if (w_fim_pisca) r_pisca <= ~r_pisca;
    end else
      r_pisca <= 1'b0;
  end

  always_comb begin
    vidas          = r_vidas;
    colisao_aceita = (r_estado == DECREMENTA);
    invulneravel   = (r_estado == INVULNERAVEL);
    pisca          = r_pisca && (r_estado == INVULNERAVEL);
    sem_vidas      = (r_estado == FIM);
    case (r_estado)
      OCIOSO, ATIVO, DECREMENTA, INVULNERAVEL, FIM: db_estado = r_estado;
      default:                                      db_estado = DB_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_gerenciador_vidas.sv
// Bench for gerenciador_vidas: directed table, multi-cycle corner sequences
// and random traffic, all compared against a countdown-style reference model.
module tb_gerenciador_vidas;

  localparam int VW  = 4;
  localparam int INV = 8;
  localparam int DIV = 2;

  logic          clock, reset, carrega, colisao, tick;
  logic [1:0]    vidas_sel;
  logic [VW-1:0] vidas;
  logic          colisao_aceita, invulneravel, pisca, sem_vidas;
  logic [3:0]    db_estado;

  gerenciador_vidas #(.VIDAS_W(VW), .INV_TICKS(INV), .PISCA_DIV(DIV)) dut (
    .clock          (clock),
    .reset          (reset),
    .carrega        (carrega),
    .vidas_sel      (vidas_sel),
    .colisao        (colisao),
    .tick           (tick),
    .vidas          (vidas),
    .colisao_aceita (colisao_aceita),
    .invulneravel   (invulneravel),
    .pisca          (pisca),
    .sem_vidas      (sem_vidas),
    .db_estado      (db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: game flags, lives, and remaining window ticks.
  int m_vidas, m_on, m_fim, m_ack, m_janela, m_vistos;

  task automatic model_reset();
    m_vidas = 0; m_on = 0; m_fim = 0; m_ack = 0; m_janela = 0; m_vistos = 0;
  endtask

  task automatic model_update(input int car, input int sel, input int col, input int tk);
    if (car != 0) begin
      m_vidas = 2 * sel + 1; m_on = 1; m_fim = 0; m_ack = 0; m_janela = 0; m_vistos = 0;
    end else if (m_on != 0 && m_fim == 0) begin
      if (m_ack != 0) begin
        m_ack = 0;
        if (m_vidas <= 1) begin
          m_vidas = 0; m_fim = 1;
        end else begin
          m_vidas = m_vidas - 1; m_janela = INV; m_vistos = 0;
        end
      end else if (m_janela > 0) begin
        if (tk != 0) begin
          m_vistos = m_vistos + 1; m_janela = m_janela - 1;
        end
      end else if (col != 0) begin
        m_ack = 1;
      end
    end
  endtask

  function automatic int m_db();
    if (m_fim != 0)       return 4;
    else if (m_on == 0)   return 0;
    else if (m_ack != 0)  return 2;
    else if (m_janela > 0) return 3;
    else                  return 1;
  endfunction

  function automatic int m_pisca();
    return (m_janela > 0 && ((m_vistos / DIV) % 2) == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("mdl_vidas", int'(vidas), m_vidas);
    chk("mdl_ack", int'(colisao_aceita), m_ack);
    chk("mdl_inv", int'(invulneravel), (m_janela > 0) ? 1 : 0);
    chk("mdl_pisca", int'(pisca), m_pisca());
    chk("mdl_sem", int'(sem_vidas), m_fim);
    chk("mdl_db", int'(db_estado), m_db());
  endtask

  task automatic step(input int car, input int sel, input int col, input int tk);
    carrega   = (car != 0);
    vidas_sel = sel[1:0];
    colisao   = (col != 0);
    tick      = (tk != 0);
    @(posedge clock);
    #1;
    model_update(car, sel, col, tk);
    compare_model();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vidas"}, int'(vidas), 0);
    chk({nm, "_ack"}, int'(colisao_aceita), 0);
    chk({nm, "_inv"}, int'(invulneravel), 0);
    chk({nm, "_pisca"}, int'(pisca), 0);
    chk({nm, "_sem"}, int'(sem_vidas), 0);
    chk({nm, "_db"}, int'(db_estado), 0);
  endtask

  typedef struct {
    int car, sel, col, tk;
    int vidas, ack, inv, pis, sem, db;
  } vec_t;

  vec_t tab [13];
  int   acks;

  initial begin
    // load 5 lives, single collision, then walk the 8-tick window
    tab[0]  = '{1, 2, 0, 0,  5, 0, 0, 0, 0, 1};
    tab[1]  = '{0, 2, 1, 0,  5, 1, 0, 0, 0, 2};
    tab[2]  = '{0, 2, 0, 0,  4, 0, 1, 1, 0, 3};
    tab[3]  = '{0, 2, 0, 1,  4, 0, 1, 1, 0, 3};
    tab[4]  = '{0, 2, 0, 1,  4, 0, 1, 0, 0, 3};
    tab[5]  = '{0, 2, 0, 0,  4, 0, 1, 0, 0, 3};
    tab[6]  = '{0, 2, 0, 1,  4, 0, 1, 0, 0, 3};
    tab[7]  = '{0, 2, 0, 1,  4, 0, 1, 1, 0, 3};
    tab[8]  = '{0, 2, 0, 1,  4, 0, 1, 1, 0, 3};
    tab[9]  = '{0, 2, 0, 1,  4, 0, 1, 0, 0, 3};
    tab[10] = '{0, 2, 1, 1,  4, 0, 1, 0, 0, 3};
    tab[11] = '{0, 2, 0, 1,  4, 0, 0, 0, 0, 1};
    tab[12] = '{0, 2, 0, 0,  4, 0, 0, 0, 0, 1};

    reset = 1'b1; carrega = 1'b0; vidas_sel = 2'd0; colisao = 1'b0; tick = 1'b0;
    model_reset();
    #13;
    chk_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // idle state ignores collisions and ticks before the first load
    step(0, 0, 1, 1);
    chk("ocioso_db", int'(db_estado), 0);

    foreach (tab[i]) begin
      step(tab[i].car, tab[i].sel, tab[i].col, tab[i].tk);
      chk("tab_vidas", int'(vidas), tab[i].vidas);
      chk("tab_ack", int'(colisao_aceita), tab[i].ack);
      chk("tab_inv", int'(invulneravel), tab[i].inv);
      chk("tab_pisca", int'(pisca), tab[i].pis);
      chk("tab_sem", int'(sem_vidas), tab[i].sem);
      chk("tab_db", int'(db_estado), tab[i].db);
    end

    // held collision, tick every third cycle: one charge per window
    step(1, 2, 0, 0);
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 2, 1, (k % 3 == 2) ? 1 : 0);
      if (colisao_aceita) acks++;
    end
    chk("nivel_acks", acks, 2);
    chk("nivel_vidas", int'(vidas), 3);
    step(0, 2, 0, 0);

    // last life: game over and nothing moves afterwards
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("ultima_ack", int'(colisao_aceita), 1);
    step(0, 0, 0, 0);
    chk("fim_vidas", int'(vidas), 0);
    chk("fim_sem", int'(sem_vidas), 1);
    chk("fim_db", int'(db_estado), 4);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 1);
      chk("fim_preso_sem", int'(sem_vidas), 1);
      chk("fim_preso_ack", int'(colisao_aceita), 0);
    end

    // reload from INVULNERAVEL with a simultaneous collision
    step(1, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk("pre_recarga_inv", int'(invulneravel), 1);
    step(1, 3, 1, 1);
    chk("recarga_inv_vidas", int'(vidas), 7);
    chk("recarga_inv_db", int'(db_estado), 1);
    chk("recarga_inv_ack", int'(colisao_aceita), 0);
    step(0, 3, 0, 0);
    chk("recarga_inv_ack2", int'(colisao_aceita), 0);

    // reload from FIM with a simultaneous collision
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("pre_recarga_fim", int'(sem_vidas), 1);
    step(1, 2, 1, 0);
    chk("recarga_fim_vidas", int'(vidas), 5);
    chk("recarga_fim_db", int'(db_estado), 1);
    chk("recarga_fim_sem", int'(sem_vidas), 0);
    step(0, 2, 0, 0);
    chk("recarga_fim_ack", int'(colisao_aceita), 0);

    // asynchronous reset between edges in the middle of the window
    step(1, 2, 0, 0);
    step(0, 2, 1, 0);
    step(0, 2, 0, 1);
    chk("pre_reset_inv", int'(invulneravel), 1);
    carrega = 1'b0; colisao = 1'b0; tick = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_zero("reset_async");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(0, 2, 1, 0);
    chk("pos_reset_ack", int'(colisao_aceita), 0);
    chk("pos_reset_db", int'(db_estado), 0);
    step(0, 2, 1, 1);
    chk("pos_reset_vidas", int'(vidas), 0);

    // random traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 59) == 0) ? 1 : 0,
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
